mux_spi_receiver: RTL and testbench
===================================

# mux_spi_receiver

SPI slave that sits on the electrode-multiplexer board, terminating the serial link driven by `mux_controller` (spi_clk / spi_mosi / spi_cs). It oversamples the SPI lines on the local clock, assembles one DATA_W-bit mux word per chip-select frame, and drives the analog-mux select lines. It then holds a settle flag low for a programmable number of cycles before the EIT front end samples. It also shifts the currently applied mux word back on spi_miso for readback.

## Interface
- DATA_W, 8, mux word width in bits; also the exact number of bits per valid frame.
- SETTLE_CYCLES, 16, clk cycles mux_settled stays low after each commit (≥1).
- RESET_VAL, 8'h00, gpio_mux value after reset.

- clk  in  1  local system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI clock from master, mode 0 (idle low, sample on rising edge).
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial readback of currently applied gpio_mux, MSB first.
- gpio_mux  out  DATA_W  mux select lines, registered.
- mux_valid  out  1  one-cycle pulse when gpio_mux is updated.
- mux_settled  out  1  high when SETTLE_CYCLES have elapsed since the last update.
- frame_err  out  1  one-cycle pulse on a frame with bit count ≠ DATA_W.

## Operation
- spi_clk, spi_cs, spi_mosi each pass through a 2-flop synchronizer. A third register per line provides edge detection.
- Synchronizer reset levels: spi_cs = 1, spi_clk = 0, spi_mosi = 0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - spi_miso = 0.
  - On synced cs falling edge: bit_cnt ← 0, tx_shift ← gpio_mux, go to SHIFT.
- SHIFT:
  - Synced spi_clk rising edge: rx_shift ← {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt increments, saturating at DATA_W+1.
  - Synced spi_clk falling edge: tx_shift shifts left by one.
  - spi_miso = tx_shift[DATA_W-1] for the whole frame.
  - Synced cs rising edge with bit_cnt == DATA_W: go to COMMIT.
  - Synced cs rising edge with any other bit_cnt: pulse frame_err, go to IDLE; gpio_mux and settle counter are untouched.
- COMMIT (one cycle): gpio_mux ← rx_shift, mux_valid = 1, settle counter ← SETTLE_CYCLES, go to IDLE.
- Settle counter is independent of the FSM:
  - Decrements to 0 each cycle.
  - mux_settled = (counter == 0), registered.
  - A new commit reloads the counter even while it is still counting.
- Simultaneous events:
  - An spi_clk edge detected in the same cycle as the cs rising edge is counted before bit_cnt is evaluated.
  - A cs falling edge detected while in COMMIT is acted on in the following IDLE cycle. The edge flag is held until consumed.
- Async reset mid-frame: everything returns to reset state immediately; the partial frame is discarded and no frame_err is raised.
- Reset values: gpio_mux = RESET_VAL, mux_valid = 0, frame_err = 0, mux_settled = 1, spi_miso = 0, state IDLE, counter 0.

## Timing
- Input constraints, in clk periods:
  - spi_clk high and low phases ≥ 3 each.
  - cs fall to first spi_clk rise ≥ 4.
  - Last spi_clk fall to cs rise ≥ 3.
  - cs high time between frames ≥ 6.
- Latency is counted from the clk edge that first samples the new pin level as edge 1:
  - Edge detected at edge 3.
  - State transition at edge 3.
  - For cs rise: COMMIT at edge 4, so gpio_mux changes and mux_valid is high after edge 4.
- frame_err asserts after edge 3 of the cs rise.
- mux_settled falls with the gpio_mux update and rises exactly SETTLE_CYCLES cycles later.
- spi_miso:
  - First bit is valid 3 cycles after the cs fall is sampled.
  - Each later bit changes 3 cycles after spi_clk fall is sampled, which is before the next rising edge under the input constraints.

## Test plan
- Reset: hold rst_n low with random SPI pins -> gpio_mux = 8'h00, mux_settled = 1, mux_valid = frame_err = spi_miso = 0.
- Single write: send 8'hA5 with spi_clk half-period 5 clk -> gpio_mux = 8'hA5 four cycles after cs rise is sampled, mux_valid exactly one cycle, mux_settled low exactly 16 cycles.
- Readback: after A5, send 8'h3C -> bits captured on spi_miso at master rising edges read 8'hA5; gpio_mux becomes 8'h3C.
- Bad frames: 7-bit frame and 9-bit frame -> one frame_err pulse each, gpio_mux unchanged, no mux_valid, mux_settled unaffected.
- Back-to-back: second valid frame 8'h5A committed while settle counter is at 10 -> counter reloads, mux_settled stays low 16 cycles from the second commit.
- Reset mid-frame: assert rst_n after 4 bits of 8'hFF -> immediate reset values, no frame_err; the next full frame 8'h81 commits correctly.

Source files
------------

// File: rtl/mux_spi_receiver_if.sv
// rtl/mux_spi_receiver_if.sv - SPI link between mux_controller (master) and mux_spi_receiver (slave)
interface mux_spi_receiver_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_clk,
        output spi_cs,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_clk,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/mux_spi_receiver.sv
// rtl/mux_spi_receiver.sv - oversampling SPI slave driving electrode mux select lines with settle flag
module mux_spi_receiver #(
    parameter int                DATA_W        = 8,
    parameter int                SETTLE_CYCLES = 16,
    parameter logic [DATA_W-1:0] RESET_VAL     = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_spi_receiver_if.slave    spi,
    output logic [DATA_W-1:0]    gpio_mux,
    output logic                 mux_valid,
    output logic                 mux_settled,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            state, state_next;
    logic [2:0]        clk_sr, cs_sr;
    logic [1:0]        mosi_sr;
    logic [CNT_W-1:0]  bit_cnt, cnt_inc, bit_cnt_eff;
    logic [DATA_W-1:0] rx_shift, tx_shift;
    logic [ST_W-1:0]   settle_cnt, settle_next;
    logic              cs_fall_pend;
    logic              clk_rise, clk_fall, cs_rise, cs_fall, cs_fall_evt;
    logic              valid_next, err_next;

    // Two-flop synchronizers plus a third stage for edge detection; mosi only needs the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr  <= 3'b000;
            cs_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            clk_sr  <= {clk_sr[1:0], spi.spi_clk};
            cs_sr   <= {cs_sr[1:0], spi.spi_cs};
            mosi_sr <= {mosi_sr[0], spi.spi_mosi};
        end
    end

    assign clk_rise    = clk_sr[1] & ~clk_sr[2];
    assign clk_fall    = ~clk_sr[1] & clk_sr[2];
    assign cs_rise     = cs_sr[1] & ~cs_sr[2];
    assign cs_fall     = ~cs_sr[1] & cs_sr[2];
    assign cs_fall_evt = cs_fall | cs_fall_pend;

    // A clock edge coinciding with cs rise is counted before the frame length is judged.
    assign cnt_inc     = (bit_cnt == CNT_W'(DATA_W + 1)) ? bit_cnt : bit_cnt + CNT_W'(1);
    assign bit_cnt_eff = clk_rise ? cnt_inc : bit_cnt;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and pulse decode.
    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_evt) state_next = SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_eff == CNT_W'(DATA_W)) begin
                        state_next = COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A cs fall seen during COMMIT is remembered until IDLE consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cs_fall_pend <= 1'b0;
        else if (state == IDLE)            cs_fall_pend <= 1'b0;
        else if (state == COMMIT && cs_fall) cs_fall_pend <= 1'b1;
    end

    // Frame shift registers: receive on spi_clk rise, advance readback on spi_clk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (state == IDLE) begin
            if (cs_fall_evt) begin
                bit_cnt  <= '0;
                tx_shift <= gpio_mux;
            end
        end else if (state == SHIFT) begin
            if (clk_rise) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_sr[1]};
                bit_cnt  <= cnt_inc;
            end
            if (clk_fall) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign spi.spi_miso = (state == SHIFT) & tx_shift[DATA_W-1];

    // Mux outputs and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_mux  <= RESET_VAL;
            mux_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == COMMIT) gpio_mux <= rx_shift;
            mux_valid <= valid_next;
            frame_err <= err_next;
        end
    end

    // Settle countdown, reloaded by every commit; the flag is registered from the next count
    // so it drops on the same edge gpio_mux changes.
    always_comb begin
        settle_next = settle_cnt;
        if (state == COMMIT)      settle_next = ST_W'(SETTLE_CYCLES);
        else if (settle_cnt != 0) settle_next = settle_cnt - ST_W'(1);
    end

    // Settle counter and settled flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= '0;
            mux_settled <= 1'b1;
        end else begin
            settle_cnt  <= settle_next;
            mux_settled <= (settle_next == '0);
        end
    end

endmodule

// File: tb/tb_mux_spi_receiver.sv
// tb/tb_mux_spi_receiver.sv - directed self-checking bench for mux_spi_receiver
module tb_mux_spi_receiver;

    localparam int SETTLE_LONG = 71;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] gpio_mux, l_gpio_mux;
    logic       mux_valid, mux_settled, frame_err;
    logic       l_valid, l_settled, l_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_spi_receiver_if bus();
    mux_spi_receiver_if bus_l();

    assign bus.spi_clk    = spi_clk;
    assign bus.spi_cs     = spi_cs;
    assign bus.spi_mosi   = spi_mosi;
    assign bus_l.spi_clk  = spi_clk;
    assign bus_l.spi_cs   = spi_cs;
    assign bus_l.spi_mosi = spi_mosi;

    mux_spi_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (bus.slave),
        .gpio_mux    (gpio_mux),
        .mux_valid   (mux_valid),
        .mux_settled (mux_settled),
        .frame_err   (frame_err)
    );

    mux_spi_receiver #(.SETTLE_CYCLES(SETTLE_LONG)) dut_long (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (bus_l.slave),
        .gpio_mux    (l_gpio_mux),
        .mux_valid   (l_valid),
        .mux_settled (l_settled),
        .frame_err   (l_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends nbits (MSB first, zero-padded past 8) and returns the miso bits seen at each rise.
    task automatic spi_send(input logic [7:0] data, input int nbits, input int h,
                            output logic [7:0] rd);
        rd = 8'h00;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? data[7-i] : 1'b0;
            repeat (h) @(negedge clk);
            spi_clk = 1'b1;
            rd = {rd[6:0], bus.spi_miso};
            repeat (h) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (3) @(negedge clk);
        spi_cs = 1'b1;
    endtask

    // Observes the main DUT for n cycles after cs rise.
    task automatic watch(input int n, output int first_valid, output int first_err,
                         output int n_valid, output int n_err, output int low);
        first_valid = -1; first_err = -1; n_valid = 0; n_err = 0; low = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (mux_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
            end
            if (frame_err) begin
                n_err++;
                if (first_err < 0) first_err = k;
            end
            if (!mux_settled) low++;
        end
    endtask

    initial begin
        logic [7:0] rd;
        int fv, fe, nv, ne, low;
        int hit, seen_high, prev_settled;

        // Reset with random pin activity.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            spi_clk  = 1'($urandom_range(0, 1));
            spi_cs   = 1'($urandom_range(0, 1));
            spi_mosi = 1'($urandom_range(0, 1));
        end
        check("rst_gpio", gpio_mux, 8'h00);
        check("rst_settled", mux_settled, 1'b1);
        check("rst_valid", mux_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_miso", bus.spi_miso, 1'b0);
        spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Single write.
        spi_send(8'hA5, 8, 5, rd);
        watch(40, fv, fe, nv, ne, low);
        check("a5_latency", fv, 4);
        check("a5_nvalid", nv, 1);
        check("a5_err", ne, 0);
        check("a5_settle_low", low, 16);
        check("a5_gpio", gpio_mux, 8'hA5);
        check("a5_settled_end", mux_settled, 1'b1);
        check("a5_readback", rd, 8'h00);

        // Readback of the previous word while writing a new one.
        spi_send(8'h3C, 8, 5, rd);
        watch(40, fv, fe, nv, ne, low);
        check("3c_readback", rd, 8'hA5);
        check("3c_gpio", gpio_mux, 8'h3C);
        check("3c_nvalid", nv, 1);

        // Short and long frames.
        spi_send(8'hFF, 7, 5, rd);
        watch(40, fv, fe, nv, ne, low);
        check("f7_nerr", ne, 1);
        check("f7_err_latency", fe, 3);
        check("f7_nvalid", nv, 0);
        check("f7_settle", low, 0);
        check("f7_gpio", gpio_mux, 8'h3C);
        spi_send(8'h11, 9, 5, rd);
        watch(40, fv, fe, nv, ne, low);
        check("f9_nerr", ne, 1);
        check("f9_err_latency", fe, 3);
        check("f9_nvalid", nv, 0);
        check("f9_settle", low, 0);
        check("f9_gpio", gpio_mux, 8'h3C);

        // Back-to-back commits while the long settle counter is still running.
        spi_send(8'h77, 8, 3, rd);
        repeat (6) @(negedge clk);
        spi_send(8'h5A, 8, 3, rd);
        hit = 0; seen_high = 0; low = 0; prev_settled = 1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (hit == 0 && l_valid) begin
                hit = 1;
                check("b2b_low_before", prev_settled, 0);
                check("b2b_latency", k, 4);
                if (!l_settled) low++;
            end else if (hit == 1 && seen_high == 0) begin
                if (!l_settled) low++;
                else seen_high = 1;
            end
            prev_settled = int'(l_settled);
        end
        check("b2b_commit_seen", hit, 1);
        check("b2b_settle_low", low, SETTLE_LONG);
        check("b2b_long_gpio", l_gpio_mux, 8'h5A);
        check("b2b_gpio", gpio_mux, 8'h5A);

        // Reset in the middle of a frame.
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gpio", gpio_mux, 8'h00);
        check("mid_rst_settled", mux_settled, 1'b1);
        check("mid_rst_valid", mux_valid, 1'b0);
        check("mid_rst_err", frame_err, 1'b0);
        check("mid_rst_miso", bus.spi_miso, 1'b0);
        spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch(20, fv, fe, nv, ne, low);
        check("post_rst_err", ne, 0);
        check("post_rst_valid", nv, 0);
        spi_send(8'h81, 8, 5, rd);
        watch(40, fv, fe, nv, ne, low);
        check("81_readback", rd, 8'h00);
        check("81_gpio", gpio_mux, 8'h81);
        check("81_latency", fv, 4);
        check("81_err", ne, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
